// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv core.
// Provides the machine word and register-address types, the commit-channel
// payload carried from the exec-mem units to commit, and the commit port
// enumeration used to index the arbiter.
package hsv_core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned NumPorts  = 4;
  localparam int unsigned PortIdxW  = 2;

  typedef logic [XLEN-1:0]     word;
  typedef logic [RegAddrW-1:0] reg_addr;

  typedef struct packed {
    word     pc;
    reg_addr rd_addr;
    word     rd_value;
    logic    writeback;
    logic    jump;
    word     jump_target;
  } commit_data_t;

  // Arbiter index of each exec-mem result channel.
  typedef enum logic [PortIdxW-1:0] {
    ALU         = 2'd0,
    BRANCH      = 2'd1,
    CTRL_STATUS = 2'd2,
    MEM         = 2'd3
  } commit_port_e;

endpackage

// File: rtl/hsv_core_commit_arbiter.sv
// 4-way round-robin arbiter for the commit stage.
// Ports:
//   clk_core, rst_core_n : clock, asynchronous active-low reset
//   req_i                : per-channel request (already masked by commit state)
//   advance_i            : a handshake happened; move the pointer past the grant
//   grant_o              : one-hot grant, combinational from req_i and the pointer
module hsv_core_commit_arbiter
  import hsv_core_pkg::*;
(
  input  logic                clk_core,
  input  logic                rst_core_n,
  input  logic [NumPorts-1:0] req_i,
  input  logic                advance_i,
  output logic [NumPorts-1:0] grant_o
);

  logic [PortIdxW-1:0] ptr_q, ptr_d;
  logic [PortIdxW-1:0] idx;
  logic [PortIdxW-1:0] gnt_idx;
  logic                found;

  // Search starts at the pointer and wraps; first requester wins.
  always_comb begin
    grant_o = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = ptr_q + PortIdxW'(i);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        gnt_idx      = idx;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = gnt_idx + PortIdxW'(1);
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      ptr_q <= PortIdxW'(ALU);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hsv_core_commit.sv
// Commit/writeback stage of the hsv core.
// Sinks results from the ALU, branch, control-status and memory units
// (valid/ready, round-robin arbitrated, at most one per cycle), drives the
// register-file write port, starts the flush handshake on taken jumps with a
// one-cycle redirect pulse, and counts retired instructions.
// Ports:
//   clk_core, rst_core_n          : clock, asynchronous active-low reset
//   <unit>_commit/_valid_i/_ready_o : result channels (alu, branch, ctrl_status, mem)
//   wr_addr, wr_data, wr_en       : register-file write port
//   flush_req, flush_ack          : pipeline flush handshake
//   redirect_valid, redirect_pc   : fetch restart pulse and address
//   retired                       : committed instruction count (wraps)
module hsv_core_commit
  import hsv_core_pkg::*;
#(
  parameter int unsigned RETIRE_W = 64
) (
  input  logic                clk_core,
  input  logic                rst_core_n,
  input  commit_data_t        alu_commit,
  input  logic                alu_valid_i,
  output logic                alu_ready_o,
  input  commit_data_t        branch_commit,
  input  logic                branch_valid_i,
  output logic                branch_ready_o,
  input  commit_data_t        ctrl_status_commit,
  input  logic                ctrl_status_valid_i,
  output logic                ctrl_status_ready_o,
  input  commit_data_t        mem_commit,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  output reg_addr             wr_addr,
  output word                 wr_data,
  output logic                wr_en,
  output logic                flush_req,
  input  logic                flush_ack,
  output logic                redirect_valid,
  output word                 redirect_pc,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e              state_q, state_d;
  logic                run_en_q;
  logic [NumPorts-1:0] req, grant;
  logic                handshake;
  commit_data_t        sel;

  reg_addr             wr_addr_q, wr_addr_d;
  word                 wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                flush_req_q, flush_req_d;
  logic                redirect_valid_q, redirect_valid_d;
  word                 redirect_pc_q, redirect_pc_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // run_en_q holds ready low for the cycle in which reset is released.
  always_comb begin
    req = '0;
    if (state_q == StRun && run_en_q) begin
      req = {mem_valid_i, ctrl_status_valid_i, branch_valid_i, alu_valid_i};
    end
  end

  hsv_core_commit_arbiter u_arbiter (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .req_i      (req),
    .advance_i  (handshake),
    .grant_o    (grant)
  );

  assign handshake           = |grant;
  assign alu_ready_o         = grant[ALU];
  assign branch_ready_o      = grant[BRANCH];
  assign ctrl_status_ready_o = grant[CTRL_STATUS];
  assign mem_ready_o         = grant[MEM];

  always_comb begin
    sel = '0;
    unique case (grant)
      4'b0001: sel = alu_commit;
      4'b0010: sel = branch_commit;
      4'b0100: sel = ctrl_status_commit;
      4'b1000: sel = mem_commit;
      default: sel = '0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    wr_en_d          = 1'b0;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    flush_req_d      = flush_req_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    retired_d        = retired_q;
    unique case (state_q)
      StRun: begin
        if (handshake) begin
          // Link writeback of a jump still commits alongside the flush.
          wr_en_d   = sel.writeback && (sel.rd_addr != '0);
          wr_addr_d = sel.rd_addr;
          wr_data_d = sel.rd_value;
          retired_d = retired_q + RETIRE_W'(1);
          if (sel.jump) begin
            flush_req_d      = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = sel.jump_target;
            state_d          = StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_ack) begin
          flush_req_d = 1'b0;
          state_d     = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q          <= StRun;
      run_en_q         <= 1'b0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      retired_q        <= '0;
    end else begin
      state_q          <= state_d;
      run_en_q         <= 1'b1;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      flush_req_q      <= flush_req_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      retired_q        <= retired_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign flush_req      = flush_req_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_hsv_core_commit.sv
// Directed self-checking bench for hsv_core_commit. A second instance with a
// 3-bit counter shares all inputs so that counter wrap-around is exercised.
module tb_hsv_core_commit;
  import hsv_core_pkg::*;

  logic         clk_core = 1'b0;
  logic         rst_core_n = 1'b0;
  commit_data_t alu_commit, branch_commit, ctrl_status_commit, mem_commit;
  logic         alu_valid_i = 1'b0, branch_valid_i = 1'b0;
  logic         ctrl_status_valid_i = 1'b0, mem_valid_i = 1'b0;
  logic         alu_ready_o, branch_ready_o, ctrl_status_ready_o, mem_ready_o;
  reg_addr      wr_addr;
  word          wr_data;
  logic         wr_en, flush_req, redirect_valid;
  logic         flush_ack = 1'b0;
  word          redirect_pc;
  logic [63:0]  retired;

  logic         s_alu_rdy, s_br_rdy, s_cs_rdy, s_mem_rdy;
  reg_addr      s_wr_addr;
  word          s_wr_data, s_redirect_pc;
  logic         s_wr_en, s_flush_req, s_redirect_valid;
  logic [2:0]   s_retired;

  logic [3:0]   rdy;
  int           n_asserts = 0;
  int           n_fail = 0;

  always #5 clk_core = ~clk_core;

  assign rdy = {mem_ready_o, ctrl_status_ready_o, branch_ready_o, alu_ready_o};

  hsv_core_commit #(.RETIRE_W(64)) dut (
    .clk_core            (clk_core),
    .rst_core_n          (rst_core_n),
    .alu_commit          (alu_commit),
    .alu_valid_i         (alu_valid_i),
    .alu_ready_o         (alu_ready_o),
    .branch_commit       (branch_commit),
    .branch_valid_i      (branch_valid_i),
    .branch_ready_o      (branch_ready_o),
    .ctrl_status_commit  (ctrl_status_commit),
    .ctrl_status_valid_i (ctrl_status_valid_i),
    .ctrl_status_ready_o (ctrl_status_ready_o),
    .mem_commit          (mem_commit),
    .mem_valid_i         (mem_valid_i),
    .mem_ready_o         (mem_ready_o),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_en               (wr_en),
    .flush_req           (flush_req),
    .flush_ack           (flush_ack),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .retired             (retired)
  );

  hsv_core_commit #(.RETIRE_W(3)) dut_small (
    .clk_core            (clk_core),
    .rst_core_n          (rst_core_n),
    .alu_commit          (alu_commit),
    .alu_valid_i         (alu_valid_i),
    .alu_ready_o         (s_alu_rdy),
    .branch_commit       (branch_commit),
    .branch_valid_i      (branch_valid_i),
    .branch_ready_o      (s_br_rdy),
    .ctrl_status_commit  (ctrl_status_commit),
    .ctrl_status_valid_i (ctrl_status_valid_i),
    .ctrl_status_ready_o (s_cs_rdy),
    .mem_commit          (mem_commit),
    .mem_valid_i         (mem_valid_i),
    .mem_ready_o         (s_mem_rdy),
    .wr_addr             (s_wr_addr),
    .wr_data             (s_wr_data),
    .wr_en               (s_wr_en),
    .flush_req           (s_flush_req),
    .flush_ack           (flush_ack),
    .redirect_valid      (s_redirect_valid),
    .redirect_pc         (s_redirect_pc),
    .retired             (s_retired)
  );

  function automatic commit_data_t mk(input word pc, input reg_addr rd, input word val,
                                      input logic wb, input logic jmp, input word tgt);
    commit_data_t c;
    c.pc          = pc;
    c.rd_addr     = rd;
    c.rd_value    = val;
    c.writeback   = wb;
    c.jump        = jmp;
    c.jump_target = tgt;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the full-width counter and the 3-bit (wrapping) copy together.
  task automatic chk_ret(input string tag, input logic [63:0] exp);
    chk({tag, "_retired"}, retired, exp);
    chk({tag, "_retired_w3"}, 64'(s_retired), exp % 8);
  endtask

  task automatic tick();
    @(posedge clk_core);
    #2;
  endtask

  initial begin
    alu_commit         = '0;
    branch_commit      = '0;
    ctrl_status_commit = '0;
    mem_commit         = '0;

    // Reset values; a valid input must not be accepted while in reset.
    alu_valid_i = 1'b1;
    #12;
    chk("rst_wr_en", 64'(wr_en), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_wr_data", 64'(wr_data), 0);
    chk("rst_flush_req", 64'(flush_req), 0);
    chk("rst_redirect_valid", 64'(redirect_valid), 0);
    chk("rst_redirect_pc", 64'(redirect_pc), 0);
    chk_ret("rst", 0);
    chk("rst_ready", 64'(rdy), 0);
    alu_valid_i = 1'b0;
    #1 rst_core_n = 1'b1;
    tick();

    // ALU alone, rd=5.
    alu_commit  = mk(32'h100, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    alu_valid_i = 1'b1;
    #1 chk("alu_ready", 64'(rdy), 4'b0001);
    tick();
    alu_valid_i = 1'b0;
    chk("alu_wr_en", 64'(wr_en), 1);
    chk("alu_wr_addr", 64'(wr_addr), 5);
    chk("alu_wr_data", 64'(wr_data), 32'hDEADBEEF);
    chk_ret("alu", 1);
    tick();
    chk("alu_wr_en_drop", 64'(wr_en), 0);

    // Write to x0 retires but does not write (pointer now at branch).
    alu_commit  = mk(32'h104, 5'd0, 32'h1234, 1'b1, 1'b0, 32'h0);
    alu_valid_i = 1'b1;
    #1 chk("x0_ready", 64'(rdy), 4'b0001);
    tick();
    alu_valid_i = 1'b0;
    chk("x0_wr_en", 64'(wr_en), 0);
    chk_ret("x0", 2);

    // All four valid: pointer is at branch, so branch, ctrl, mem, alu.
    alu_commit         = mk(32'h10, 5'd10, 32'hA000, 1'b1, 1'b0, 32'h0);
    branch_commit      = mk(32'h14, 5'd11, 32'hA001, 1'b1, 1'b0, 32'h0);
    ctrl_status_commit = mk(32'h18, 5'd12, 32'hA002, 1'b1, 1'b0, 32'h0);
    mem_commit         = mk(32'h1C, 5'd13, 32'hA003, 1'b1, 1'b0, 32'h0);
    {alu_valid_i, branch_valid_i, ctrl_status_valid_i, mem_valid_i} = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (1 + k) % 4;
      #1 chk("rr_grant", 64'(rdy), 64'(1) << p);
      tick();
      chk("rr_wr_en", 64'(wr_en), 1);
      chk("rr_wr_addr", 64'(wr_addr), 64'(10 + p));
      chk("rr_wr_data", 64'(wr_data), 64'(32'hA000 + p));
      chk_ret("rr", 64'(3 + k));
    end
    {alu_valid_i, branch_valid_i, ctrl_status_valid_i, mem_valid_i} = 4'b0000;

    // Taken branch with link to x1; mem held valid through the flush.
    branch_commit  = mk(32'h200, 5'd1, 32'h204, 1'b1, 1'b1, 32'h80000100);
    mem_commit     = mk(32'h300, 5'd7, 32'h77, 1'b1, 1'b0, 32'h0);
    branch_valid_i = 1'b1;
    mem_valid_i    = 1'b1;
    #1 chk("br_ready", 64'(rdy), 4'b0010);
    tick();
    branch_valid_i = 1'b0;
    #1;
    chk("br_wr_en", 64'(wr_en), 1);
    chk("br_wr_addr", 64'(wr_addr), 1);
    chk("br_wr_data", 64'(wr_data), 32'h204);
    chk("br_flush_req", 64'(flush_req), 1);
    chk("br_redirect_valid", 64'(redirect_valid), 1);
    chk("br_redirect_pc", 64'(redirect_pc), 32'h80000100);
    chk_ret("br", 7);
    chk("br_flush_ready", 64'(rdy), 0);
    tick();
    chk("fl2_redirect_valid", 64'(redirect_valid), 0);
    chk("fl2_flush_req", 64'(flush_req), 1);
    chk("fl2_wr_en", 64'(wr_en), 0);
    chk("fl2_ready", 64'(rdy), 0);
    tick();
    flush_ack = 1'b1;
    #1;
    chk("fl3_flush_req", 64'(flush_req), 1);
    chk("fl3_ready", 64'(rdy), 0);
    tick();
    flush_ack = 1'b0;
    #1;
    chk("fl4_flush_req", 64'(flush_req), 0);
    chk("fl4_mem_ready", 64'(rdy), 4'b1000);
    tick();
    mem_valid_i = 1'b0;
    chk("mem_wr_en", 64'(wr_en), 1);
    chk("mem_wr_addr", 64'(wr_addr), 7);
    chk("mem_wr_data", 64'(wr_data), 32'h77);
    chk_ret("mem", 8);

    // flush_ack in RUN has no effect.
    flush_ack   = 1'b1;
    alu_commit  = mk(32'h400, 5'd3, 32'h33, 1'b1, 1'b0, 32'h0);
    alu_valid_i = 1'b1;
    #1 chk("ack_run_ready", 64'(rdy), 4'b0001);
    tick();
    flush_ack   = 1'b0;
    alu_valid_i = 1'b0;
    chk("ack_run_flush_req", 64'(flush_req), 0);
    chk("ack_run_wr_addr", 64'(wr_addr), 3);
    chk_ret("ack_run", 9);

    // Jump from ALU without writeback, then reset while flushing.
    alu_commit  = mk(32'h500, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1000);
    alu_valid_i = 1'b1;
    #1 chk("j2_ready", 64'(rdy), 4'b0001);
    tick();
    alu_valid_i = 1'b0;
    #1;
    chk("j2_flush_req", 64'(flush_req), 1);
    chk("j2_wr_en", 64'(wr_en), 0);
    chk("j2_redirect_pc", 64'(redirect_pc), 32'h1000);
    chk_ret("j2", 10);
    alu_commit = mk(32'h10, 5'd10, 32'hA000, 1'b1, 1'b0, 32'h0);
    {alu_valid_i, branch_valid_i, ctrl_status_valid_i, mem_valid_i} = 4'b1111;
    rst_core_n = 1'b0;
    #1;
    chk("mrst_flush_req", 64'(flush_req), 0);
    chk("mrst_wr_en", 64'(wr_en), 0);
    chk("mrst_redirect_valid", 64'(redirect_valid), 0);
    chk("mrst_redirect_pc", 64'(redirect_pc), 0);
    chk("mrst_ready", 64'(rdy), 0);
    chk_ret("mrst", 0);
    #1 rst_core_n = 1'b1;
    #1 chk("post_rst_ready", 64'(rdy), 0);
    tick();
    #1 chk("post_rst_alu_first", 64'(rdy), 4'b0001);
    tick();
    {alu_valid_i, branch_valid_i, ctrl_status_valid_i, mem_valid_i} = 4'b0000;
    chk("post_rst_wr_addr", 64'(wr_addr), 10);
    chk("post_rst_wr_data", 64'(wr_data), 32'hA000);
    chk_ret("post_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required end of sequence");
    $fatal(1, "timeout");
  end

endmodule
